// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller: drives trial values into an external
// comparator (cmp_gt = trial > target) and recovers the target MSB-first.
module sar_search_ctrl #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             cmp_gt,
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int IW = $clog2(WIDTH);
    localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [IW-1:0]    IDX_MSB  = IW'(WIDTH - 1);
    localparam logic [CW-1:0]    SETTLE_C = CW'(SETTLE);
    localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_STEP = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] trial_q, trial_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Next-state and output decisions; cmp_gt is only consulted on the sample cycle
    always_comb begin
        state_d  = state_q;
        trial_d  = trial_q;
        result_d = result_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    state_d = S_STEP;
                    trial_d = MSB_ONLY;
                    idx_d   = IDX_MSB;
                    cnt_d   = {CW{1'b0}};
                    busy_d  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_STEP: begin
                if (abort) begin
                    state_d = S_IDLE;
                    trial_d = {WIDTH{1'b0}};
                    idx_d   = IDX_MSB;
                    cnt_d   = {CW{1'b0}};
                    busy_d  = 1'b0;
                end else if (cnt_q != SETTLE_C) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    if (cmp_gt) begin
                        trial_d[idx_q] = 1'b0;
                    end else begin
                        trial_d[idx_q] = 1'b1;
                    end
                    if (idx_q != {IW{1'b0}}) begin
                        trial_d[idx_q - 1'b1] = 1'b1;
                        idx_d = idx_q - 1'b1;
                        cnt_d = {CW{1'b0}};
                    end else begin
                        // The decided trial doubles as the result and stays on the comparator
                        result_d = trial_d;
                        done_d   = 1'b1;
                        busy_d   = 1'b0;
                        state_d  = S_IDLE;
                        idx_d    = IDX_MSB;
                        cnt_d    = {CW{1'b0}};
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                trial_d = {WIDTH{1'b0}};
                idx_d   = IDX_MSB;
                cnt_d   = {CW{1'b0}};
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            trial_q  <= {WIDTH{1'b0}};
            result_q <= {WIDTH{1'b0}};
            idx_q    <= IDX_MSB;
            cnt_q    <= {CW{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            trial_q  <= trial_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign trial  = trial_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Randomised self-checking bench for sar_search_ctrl: two instances (SETTLE=0 and 2)
// each driven by a behavioural comparator; expectations come from the target value.
module tb_sar_search_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start0, abort0, cmp0;
    logic [3:0] trial0, result0, tgt0;
    logic       busy0, done0;
    logic       start2, abort2, cmp2;
    logic [3:0] trial2, result2, tgt2;
    logic       busy2, done2;

    int n_pass;
    int n_total;

    sar_search_ctrl #(.WIDTH(4), .SETTLE(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .cmp_gt(cmp0),
        .trial(trial0), .busy(busy0), .done(done0), .result(result0)
    );

    sar_search_ctrl #(.WIDTH(4), .SETTLE(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .cmp_gt(cmp2),
        .trial(trial2), .busy(busy2), .done(done2), .result(result2)
    );

    // Ideal comparator for the SETTLE=0 instance
    assign cmp0 = (trial0 > tgt0);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Trial while bit i is being decided: bits above i equal target, bit i set, rest clear
    function automatic logic [3:0] exp_trial(input logic [3:0] t, input int i);
        int v;
        v = ((int'(t) >> (i + 1)) << (i + 1)) | (1 << i);
        return v[3:0];
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One full SETTLE=0 conversion; ends in the done cycle (negedge)
    task automatic convert0(input logic [3:0] tgt, input bit respulse, input bit with_abort);
        tgt0   = tgt;
        start0 = 1'b1;
        abort0 = with_abort;
        step();
        start0 = 1'b0;
        abort0 = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            check("trial0", 32'(trial0), 32'(exp_trial(tgt, i)));
            check("busy0", 32'(busy0), 32'd1);
            check("done0_low", 32'(done0), 32'd0);
            start0 = respulse && (i == 2 || i == 1);
            step();
        end
        start0 = 1'b0;
        check("busy0_fall", 32'(busy0), 32'd0);
        check("done0_pulse", 32'(done0), 32'd1);
        check("result0", 32'(result0), 32'(tgt));
        check("trial0_final", 32'(trial0), 32'(tgt));
    endtask

    initial begin
        logic [3:0] t;
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        start0  = 1'b0; abort0 = 1'b0; tgt0 = 4'd0;
        start2  = 1'b0; abort2 = 1'b0; tgt2 = 4'd0; cmp2 = 1'b0;
        step();
        check("rst_trial0", 32'(trial0), 32'd0);
        check("rst_busy0", 32'(busy0), 32'd0);
        check("rst_done0", 32'(done0), 32'd0);
        check("rst_result0", 32'(result0), 32'd0);
        check("rst_busy2", 32'(busy2), 32'd0);
        rst_n = 1'b1;
        step();

        // Directed example, then a back-to-back sweep of every target
        convert0(4'b1011, 1'b0, 1'b0);
        for (int v = 0; v < 16; v++) begin
            convert0(4'(v), 1'b0, 1'b0);
        end
        step();
        check("done0_single", 32'(done0), 32'd0);

        // Random targets, some with start re-pulsed mid-conversion
        for (int n = 0; n < 20; n++) begin
            t = 4'($urandom_range(0, 15));
            convert0(t, 1'($urandom_range(0, 1)), 1'b0);
        end
        step();

        convert0(4'b0101, 1'b1, 1'b0);
        step();
        check("respulse_done_once", 32'(done0), 32'd0);
        check("respulse_idle", 32'(busy0), 32'd0);

        // Abort in IDLE does nothing; start plus abort in IDLE starts
        abort0 = 1'b1;
        step();
        abort0 = 1'b0;
        check("idle_abort_busy", 32'(busy0), 32'd0);
        check("idle_abort_result", 32'(result0), 32'b0101);
        convert0(4'b0011, 1'b0, 1'b1);
        step();
        convert0(4'b0101, 1'b0, 1'b0);
        step();

        // Abort mid-conversion
        tgt0 = 4'b1110; start0 = 1'b1;
        step();
        start0 = 1'b0;
        step();
        abort0 = 1'b1;
        step();
        abort0 = 1'b0;
        check("abort_busy", 32'(busy0), 32'd0);
        check("abort_trial", 32'(trial0), 32'd0);
        check("abort_done", 32'(done0), 32'd0);
        check("abort_result", 32'(result0), 32'b0101);
        step();
        check("abort_no_late_done", 32'(done0), 32'd0);
        convert0(4'b1110, 1'b0, 1'b0);
        step();

        // Abort on the final sample edge wins over completion
        tgt0 = 4'b0110; start0 = 1'b1;
        step();
        start0 = 1'b0;
        for (int i = 0; i < 3; i++) step();
        abort0 = 1'b1;
        step();
        abort0 = 1'b0;
        check("abort_last_done", 32'(done0), 32'd0);
        check("abort_last_busy", 32'(busy0), 32'd0);
        check("abort_last_result", 32'(result0), 32'b1110);
        step();
        check("abort_last_done2", 32'(done0), 32'd0);

        // SETTLE=2: comparator output is junk except on sample edges
        tgt2 = 4'b0110; start2 = 1'b1;
        cmp2 = 1'($urandom_range(0, 1));
        step();
        start2 = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            check("busy2", 32'(busy2), 32'd1);
            check("done2_low", 32'(done2), 32'd0);
            check("trial2", 32'(trial2), 32'(exp_trial(tgt2, 3 - (k - 1) / 3)));
            cmp2 = (k % 3 == 0) ? (trial2 > tgt2) : 1'($urandom_range(0, 1));
            step();
        end
        check("busy2_fall", 32'(busy2), 32'd0);
        check("done2_pulse", 32'(done2), 32'd1);
        check("result2", 32'(result2), 32'b0110);
        step();

        // Asynchronous reset mid-conversion
        tgt0 = 4'b1100; start0 = 1'b1;
        step();
        start0 = 1'b0;
        step();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_trial", 32'(trial0), 32'd0);
        check("arst_busy", 32'(busy0), 32'd0);
        check("arst_done", 32'(done0), 32'd0);
        check("arst_result", 32'(result0), 32'd0);
        check("arst_result2", 32'(result2), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        convert0(4'b1001, 1'b0, 1'b0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sar_search_ctrl.md
Name: sar_search_ctrl

Overview:
- Successive-approximation controller at the opposite end of the team's magnitude-comparator interface: it generates trial values and consumes the comparator's single "greater-than" result.
- The external comparator is wired with a = trial and b = target, so cmp_gt = (trial > target).
- The block binary-searches MSB-first and recovers the unknown target value in WIDTH comparison steps.
- It sits between a start/done requester and a gate-level comparator instance.

Parameters:
- WIDTH, 4, bit width of the trial, target and result values (>=2).
- SETTLE, 0, extra wait cycles per bit before cmp_gt is sampled, to cover comparator settling (>=0).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a conversion; sampled only in IDLE.
- abort  input  1  synchronous cancel of an in-progress conversion.
- cmp_gt  input  1  comparator result, 1 when trial > target.
- trial  output  WIDTH  value presented to comparator input a.
- busy  output  1  conversion in progress.
- done  output  1  one-cycle pulse; result just updated.
- result  output  WIDTH  last completed conversion value.

Behaviour:
- Reset: rst_n low asynchronously forces state=IDLE, trial=0, busy=0, done=0, result=0, bit index=WIDTH-1, settle counter=0. This applies mid-conversion too; no partial result is kept.
- States: IDLE, STEP.
- IDLE:
  - busy=0.
  - start=1 at a clock edge -> STEP; trial <= only bit WIDTH-1 set; idx <= WIDTH-1; cnt <= 0; busy <= 1.
  - start=0 -> stay; trial holds its last value.
- STEP: each bit occupies exactly SETTLE+1 cycles.
  - cnt counts 0..SETTLE.
  - cmp_gt is sampled only at the edge where cnt==SETTLE and is ignored otherwise.
- Decision at sample edge:
  - if cmp_gt=1, clear trial[idx]; else keep it.
  - if idx>0, also set trial[idx-1], idx <= idx-1, cnt <= 0.
  - if idx==0: result <= final trial; trial <= the same final value; done <= 1 for one cycle; busy <= 0; -> IDLE.
- Timing:
  - Start sampled at edge 0 -> busy high for exactly WIDTH*(SETTLE+1) cycles.
  - done is high in the cycle immediately after busy falls. busy and done are never high together.
  - Result is valid from the done cycle and holds until the next completion.
- start while busy is ignored (no restart, no queueing).
- start asserted in the done cycle is accepted: back-to-back conversions, with no idle gap beyond the done cycle.
- abort=1 in STEP:
  - next edge -> IDLE, busy <= 0, trial <= 0, idx/cnt reset.
  - done is not pulsed and result is unchanged.
- abort in IDLE has no effect. abort and start together in IDLE: start wins.
- abort at the same edge as the final sample: abort wins; no done pulse, result unchanged.
- Arithmetic: unsigned only; only single-bit set/clear ops on trial; no wrap-around is possible. Targets 0 and 2^WIDTH-1 must resolve exactly.
- All outputs are registered; no combinational path from cmp_gt to any output.

Test Plan:
- WIDTH=4, SETTLE=0, target=4'b1011 modelled by a behavioural comparator, start pulse at cycle 0 -> trial sequence 1000,1100,1010,1011; busy high cycles 1-4; done=1 at cycle 5; result=1011.
- WIDTH=4, SETTLE=0, sweep all targets 0..15, one conversion each issued back-to-back via start in the done cycle -> result equals target every time, 5 cycles per conversion, including 0000 and 1111.
- WIDTH=4, SETTLE=2, target=0110; cmp_gt driven X except on sample cycles -> busy exactly 12 cycles; result=0110; no X propagates to result.
- start re-pulsed at cycles 2 and 3 during a conversion with target=0101 -> conversion unaffected, single done pulse, result=0101.
- abort at cycle 3 (previous result=0101, new target=1110) -> busy falls at cycle 4, trial=0, no done pulse, result stays 0101. A following start yields result=1110.
- rst_n pulsed low mid-conversion (asynchronously, between edges) -> trial, busy, done and result read 0 immediately. After release, a start with target=1001 gives result=1001.
